// File: rtl/mcu_spi_combined_if.sv
// SPI wire bundle between the external master and the MCU slave front end.
interface mcu_spi_combined_if;
  logic MOSI_in;
  logic sclk_in;
  logic SS_in;
  logic MISO_out;

  modport master (output MOSI_in, output sclk_in, output SS_in, input MISO_out);
  modport slave  (input MOSI_in, input sclk_in, input SS_in, output MISO_out);
endinterface

// File: rtl/mcu_spi_combined.sv
// SPI slave front end: receives four config bytes into a register map, then
// streams the selected 16-bit angle out on MISO, MSB first, on each SCLK rise.
module mcu_spi_combined (
  input  logic        clk,
  input  logic        rst,
  mcu_spi_combined_if.slave spi,
  input  logic        write_enable_in,
  input  logic [1:0]  output_select_in,
  input  logic [15:0] roll_angle_in,
  input  logic [15:0] pitch_angle_in,
  input  logic [15:0] yaw_angle_in,
  output logic [7:0]  config_data_out,
  output logic [2:0]  addr_out,
  input  logic [7:0]  data_in,
  input  logic [2:0]  addr_in,
  output logic        done_out,
  output logic        configured_out,
  output logic        data_ready_out,
  output logic [7:0]  acc_add_out,
  output logic [7:0]  gyro_add_out,
  output logic [7:0]  mag_add_out,
  output logic [7:0]  declination_out
);
  typedef enum logic [1:0] {CONFIG, WRITE, IDLE, SHIFT} state_t;

  state_t      state_q;
  logic        sclk_s1_q, sclk_s2_q, sclk_prev_q;
  logic        mosi_s1_q, mosi_s2_q;
  logic [7:0]  rx_q;
  logic [3:0]  bit_cnt_q;
  logic [1:0]  byte_idx_q;
  logic [15:0] shreg_q;
  logic        miso_q;
  logic [7:0]  config_data_q;
  logic [2:0]  addr_q;
  logic        done_q, configured_q, data_ready_q;
  logic [7:0]  acc_q, gyro_q, mag_q, decl_q;

  logic        sclk_rise;
  logic [7:0]  rx_d;
  logic [15:0] angle_d;
  logic        unused_ss;

  assign unused_ss = spi.SS_in;
  assign sclk_rise = sclk_s2_q & ~sclk_prev_q;
  assign rx_d      = {rx_q[6:0], mosi_s2_q};

  always_comb begin
    angle_d = 16'h0000;
    case (output_select_in)
      2'b00:   angle_d = roll_angle_in;
      2'b01:   angle_d = pitch_angle_in;
      2'b10:   angle_d = yaw_angle_in;
      default: angle_d = 16'h0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_s1_q   <= 1'b0;
      sclk_s2_q   <= 1'b0;
      sclk_prev_q <= 1'b0;
      mosi_s1_q   <= 1'b0;
      mosi_s2_q   <= 1'b0;
    end else begin
      sclk_s1_q   <= spi.sclk_in;
      sclk_s2_q   <= sclk_s1_q;
      sclk_prev_q <= sclk_s2_q;
      mosi_s1_q   <= spi.MOSI_in;
      mosi_s2_q   <= mosi_s1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= CONFIG;
      rx_q          <= 8'h00;
      bit_cnt_q     <= 4'd0;
      byte_idx_q    <= 2'd0;
      shreg_q       <= 16'h0000;
      miso_q        <= 1'b0;
      config_data_q <= 8'h00;
      addr_q        <= 3'b111;
      done_q        <= 1'b0;
      configured_q  <= 1'b0;
      data_ready_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        CONFIG: if (sclk_rise) begin
          rx_q <= rx_d;
          if (bit_cnt_q == 4'd7) begin
            // Present the byte during WRITE so the looped map latches it at its end.
            bit_cnt_q     <= 4'd0;
            config_data_q <= rx_d;
            addr_q        <= {1'b0, byte_idx_q};
            state_q       <= WRITE;
          end else begin
            bit_cnt_q <= bit_cnt_q + 4'd1;
          end
        end
        WRITE: begin
          addr_q     <= 3'b111;
          byte_idx_q <= byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            configured_q <= 1'b1;
            state_q      <= IDLE;
          end else begin
            state_q <= CONFIG;
          end
        end
        IDLE: if (write_enable_in && configured_q) begin
          shreg_q      <= angle_d;
          data_ready_q <= 1'b1;
          bit_cnt_q    <= 4'd0;
          state_q      <= SHIFT;
        end
        SHIFT: if (sclk_rise) begin
          miso_q    <= shreg_q[15];
          shreg_q   <= {shreg_q[14:0], 1'b0};
          bit_cnt_q <= bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd15) begin
            done_q       <= 1'b1;
            data_ready_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= CONFIG;
      endcase
    end
  end

  // Register map: written from the externally looped data_in/addr_in port.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= 8'h00;
      gyro_q <= 8'h00;
      mag_q  <= 8'h00;
      decl_q <= 8'h00;
    end else begin
      case (addr_in)
        3'b000:  acc_q  <= data_in;
        3'b001:  gyro_q <= data_in;
        3'b010:  mag_q  <= data_in;
        3'b011:  decl_q <= data_in;
        default: ;
      endcase
    end
  end

  assign spi.MISO_out     = miso_q;
  assign config_data_out  = config_data_q;
  assign addr_out         = addr_q;
  assign done_out         = done_q;
  assign configured_out   = configured_q;
  assign data_ready_out   = data_ready_q;
  assign acc_add_out      = acc_q;
  assign gyro_add_out     = gyro_q;
  assign mag_add_out      = mag_q;
  assign declination_out  = decl_q;
endmodule

// File: tb/tb_mcu_spi_combined.sv
// Self-checking bench for mcu_spi_combined: config bytes and angle words via scoreboard queues.
module tb_mcu_spi_combined;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        write_enable_in = 1'b0;
  logic [1:0]  output_select_in = 2'b00;
  logic [15:0] roll_angle_in = 16'h0000;
  logic [15:0] pitch_angle_in = 16'h0000;
  logic [15:0] yaw_angle_in = 16'h0000;
  logic [7:0]  config_data_out;
  logic [2:0]  addr_out;
  logic        done_out, configured_out, data_ready_out;
  logic [7:0]  acc_add_out, gyro_add_out, mag_add_out, declination_out;

  mcu_spi_combined_if spi ();

  mcu_spi_combined dut (
    .clk              (clk),
    .rst              (rst),
    .spi              (spi.slave),
    .write_enable_in  (write_enable_in),
    .output_select_in (output_select_in),
    .roll_angle_in    (roll_angle_in),
    .pitch_angle_in   (pitch_angle_in),
    .yaw_angle_in     (yaw_angle_in),
    .config_data_out  (config_data_out),
    .addr_out         (addr_out),
    .data_in          (config_data_out),
    .addr_in          (addr_out),
    .done_out         (done_out),
    .configured_out   (configured_out),
    .data_ready_out   (data_ready_out),
    .acc_add_out      (acc_add_out),
    .gyro_add_out     (gyro_add_out),
    .mag_add_out      (mag_add_out),
    .declination_out  (declination_out)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;
  int done_cnt = 0;
  logic [7:0]  cfg_q[$];
  logic [15:0] word_q[$];

  always @(posedge clk) if (done_out) done_cnt <= done_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sclk_bit(input logic b);
    spi.MOSI_in = b;
    tick(3);
    spi.sclk_in = 1'b1;
    tick(5);
    spi.sclk_in = 1'b0;
    tick(3);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit push);
    if (push) cfg_q.push_back(b);
    for (int i = 7; i >= 0; i--) sclk_bit(b[i]);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_miso"}, {31'd0, spi.MISO_out}, 0);
    chk({tag, "_rdy"},  {31'd0, data_ready_out}, 0);
    chk({tag, "_done"}, {31'd0, done_out}, 0);
    chk({tag, "_cfgd"}, {31'd0, configured_out}, 0);
    chk({tag, "_addr"}, {29'd0, addr_out}, 32'h7);
    chk({tag, "_cdat"}, {24'd0, config_data_out}, 0);
    chk({tag, "_regs"}, {acc_add_out, gyro_add_out, mag_add_out, declination_out}, 0);
  endtask

  task automatic pulse_we(input logic [1:0] sel);
    output_select_in = sel;
    write_enable_in  = 1'b1;
    tick(1);
    write_enable_in  = 1'b0;
  endtask

  task automatic load(input logic [1:0] sel, input logic [15:0] exp);
    pulse_we(sel);
    word_q.push_back(exp);
    tick(1);
    chk("load_rdy", {31'd0, data_ready_out}, 1);
  endtask

  // Clocks n SCLK pulses, sampling MISO 2 clocks after each fall; optional stray load mid-word.
  task automatic read_bits(input int n, input bit inject, output logic [15:0] w);
    w = 16'h0000;
    for (int i = 0; i < n; i++) begin
      if (inject && i == 8) begin
        yaw_angle_in = 16'hFFFF;
        pulse_we(2'b10);
        tick(1);
        chk("we_in_shift_rdy", {31'd0, data_ready_out}, 1);
      end
      tick(3);
      spi.sclk_in = 1'b1;
      tick(5);
      spi.sclk_in = 1'b0;
      tick(2);
      w = {w[14:0], spi.MISO_out};
      tick(1);
    end
  endtask

  task automatic read_word(input string tag, input bit inject);
    logic [15:0] w;
    int d0;
    d0 = done_cnt;
    read_bits(16, inject, w);
    tick(3);
    if (word_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
    end else begin
      chk({tag, "_word"}, {16'd0, w}, {16'd0, word_q.pop_front()});
    end
    chk({tag, "_done"}, done_cnt - d0, 1);
    chk({tag, "_rdy"}, {31'd0, data_ready_out}, 0);
  endtask

  initial begin
    logic [15:0] tmp;
    spi.MOSI_in = 1'b0;
    spi.sclk_in = 1'b0;
    spi.SS_in   = 1'b0;
    tick(3);
    check_reset_state("rst");
    rst = 1'b0;
    tick(2);

    // Partial byte, then reset: next full byte must land in acc.
    for (int i = 0; i < 4; i++) sclk_bit(1'b1);
    rst = 1'b1; tick(2); rst = 1'b0;
    check_reset_state("rst_midcfg");

    send_byte(8'h55, 1'b1);
    tick(3);
    chk("acc", {24'd0, acc_add_out}, {24'd0, cfg_q.pop_front()});
    chk("cfgd_early", {31'd0, configured_out}, 0);

    roll_angle_in  = 16'h0F0F;
    pitch_angle_in = 16'hA5C3;
    yaw_angle_in   = 16'h5E0D;
    pulse_we(2'b00);
    tick(1);
    chk("we_unconfigured", {31'd0, data_ready_out}, 0);

    send_byte(8'h0F, 1'b1);
    send_byte(8'h81, 1'b1);
    send_byte(8'h05, 1'b1);
    tick(3);
    chk("gyro", {24'd0, gyro_add_out}, {24'd0, cfg_q.pop_front()});
    chk("mag",  {24'd0, mag_add_out},  {24'd0, cfg_q.pop_front()});
    chk("decl", {24'd0, declination_out}, {24'd0, cfg_q.pop_front()});
    chk("acc_kept", {24'd0, acc_add_out}, 32'h55);
    chk("cfgd", {31'd0, configured_out}, 1);
    chk("addr_idle", {29'd0, addr_out}, 32'h7);

    load(2'b00, 16'h0F0F);
    roll_angle_in = 16'hFFFF;
    read_word("roll", 1'b0);
    load(2'b01, 16'hA5C3);
    read_word("pitch", 1'b1);
    yaw_angle_in = 16'h5E0D;
    load(2'b10, 16'h5E0D);
    read_word("yaw", 1'b0);
    load(2'b11, 16'h0000);
    read_word("zero", 1'b0);
    chk("cfgd_sticky", {31'd0, configured_out}, 1);

    // Reset mid-shift: drop the in-flight expectation, then reconfigure from acc.
    load(2'b01, 16'hA5C3);
    read_bits(5, 1'b0, tmp);
    rst = 1'b1; tick(2); rst = 1'b0;
    if (word_q.size() != 0) void'(word_q.pop_front());
    check_reset_state("rst_midshift");

    send_byte(8'hA3, 1'b1);
    tick(3);
    chk("acc_after_rst", {24'd0, acc_add_out}, {24'd0, cfg_q.pop_front()});
    chk("gyro_after_rst", {24'd0, gyro_add_out}, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/mcu_spi_combined.md
Name: mcu_spi_combined

Overview:
- SPI-slave front end of the attitude MCU, oversampled by the system clock.
- After reset it receives four configuration bytes on MOSI and writes them through an externally looped register-map port into four configuration registers: accelerometer address, gyro address, magnetometer address and declination.
- Once configured, each write_enable pulse loads the selected 16-bit angle (roll, pitch or yaw) into a shift register. That word is then shifted out MSB first on MISO, one bit per SPI clock.

Parameters:
- None. All widths are fixed: 8-bit config data, 3-bit address, 16-bit angles.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- write_enable_in  in  1  one-cycle pulse; loads the angle selected by output_select_in
- output_select_in  in  2  00 roll, 01 pitch, 10 yaw, 11 loads 0x0000
- MOSI_in  in  1  SPI master-out data, asynchronous to clk
- sclk_in  in  1  SPI master clock, asynchronous, at least 8 clk periods per bit
- SS_in  in  1  slave select; unused and ignored (may float)
- roll_angle_in, pitch_angle_in, yaw_angle_in  in  16 each  angle sources
- config_data_out  out  8  register-map write data
- addr_out  out  3  register-map write address; 111 when idle
- data_in  in  8  register-map write data (normally tied to config_data_out)
- addr_in  in  3  register-map address: 000 acc, 001 gyro, 010 mag, 011 declination, others no write
- MISO_out  out  1  SPI slave-out data
- done_out  out  1  one-cycle pulse when a 16-bit output finishes
- configured_out  out  1  high once all four config bytes have been written
- data_ready_out  out  1  high while a loaded word is waiting or being shifted
- acc_add_out, gyro_add_out, mag_add_out, declination_out  out  8 each  config registers

Behaviour:
- Reset values:
  - all config registers 0x00
  - config_data_out 0x00, addr_out 111
  - MISO_out 0, done_out 0, configured_out 0, data_ready_out 0
  - byte counter 0, bit counter 0, shift registers 0
- Synchronisation: sclk_in and MOSI_in pass through 2-flop synchronisers. A rising SCLK edge is detected when the synced value is 1 and its previous value was 0. MOSI is sampled at the same cycle as the detected edge.
- State machine states: CONFIG, WRITE, IDLE, SHIFT.
- CONFIG (state after reset):
  - Each detected rising SCLK edge shifts the synced MOSI bit into an 8-bit shift register, MSB first.
  - On the 8th bit, go to WRITE.
- WRITE (one cycle):
  - Drive config_data_out = received byte and addr_out = byte index (0 acc, 1 gyro, 2 mag, 3 declination).
  - Then return addr_out to 111 and increment the byte index.
  - After index 3, set configured_out and go to IDLE; otherwise go back to CONFIG.
- Register map: on each clk, if addr_in is 000..011, the addressed register loads data_in. The value is visible one cycle after WRITE.
- IDLE:
  - MOSI is ignored.
  - When write_enable_in=1, the selected angle loads into a 16-bit shift register, data_ready_out goes high the next cycle, the bit count clears, and the state moves to SHIFT.
  - write_enable_in is ignored before configured_out is high and while in SHIFT.
- SHIFT:
  - On each detected rising SCLK edge: MISO_out <= shreg[15], shreg shifts left by one, bit count increments.
  - MISO_out therefore holds each bit from one SCLK rising edge until the next. The master samples after the falling edge.
  - After the 16th edge: done_out pulses for one cycle, data_ready_out clears, state returns to IDLE.
  - MISO_out keeps its last value until the next shift.
- Angle values are captured at the load cycle; later changes on the angle inputs do not affect a transfer in progress.
- Reset asserted in any state, including mid-byte or mid-shift, returns every register to its reset value.
- configured_out is sticky until reset.

Test Plan:
- Reset, then shift in MOSI byte 0x55 (MSB first, bit set 3 clocks before SCLK rises, SCLK high 5 clocks) -> 6 clocks after the last SCLK fall, acc_add_out = 0x55 and configured_out = 0.
- Shift in 0x0F, 0x81, 0x05 -> gyro_add_out = 0x0F, mag_add_out = 0x81, declination_out = 0x05, configured_out = 1.
- roll = 0x0F0F, output_select 00, one-cycle write_enable -> data_ready_out = 1 two clocks later. 16 SCLK pulses, sampling MISO 2 clocks after each SCLK fall -> sampled word = 0x0F0F, done_out pulses once, data_ready_out returns to 0.
- Repeat with select 01 and select 10 using distinct pitch and yaw words (e.g. yaw 0x5E0D) -> each sampled word equals the selected input.
- write_enable before configuration completes, and again during SHIFT -> ignored; data_ready_out and the transfer in progress are unaffected.
- Reset asserted mid-config-byte and mid-shift -> all outputs return to reset values and the next byte is treated as acc.
